// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types, funct3 encodings and branch-outcome evaluation for the
// execute-stage branch resolve controller.
package branch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Returns {legal, taken}; funct3 010/011 are not branches.
   function automatic logic [1:0] br_taken(input logic [2:0] funct3,
                                           input logic       lt,
                                           input logic       eq);
      logic [1:0] res;
      case (funct3)
         F3_BEQ:  res = {1'b1, eq};
         F3_BNE:  res = {1'b1, ~eq};
         F3_BLT:  res = {1'b1, lt};
         F3_BGE:  res = {1'b1, ~lt};
         F3_BLTU: res = {1'b1, lt};
         F3_BGEU: res = {1'b1, ~lt};
         default: res = 2'b00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   // Count register: clear, saturating increment, or hold.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolve controller for an always-taken fetch policy:
// redirects fetch on a not-taken branch, then flushes and stalls the front end.
module branch_resolve_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ex_valid_i,
   input  logic             ex_is_br_i,
   input  logic [2:0]       ex_funct3_i,
   input  logic [WIDTH-1:0] ex_pc_i,
   input  logic             br_lt_i,
   input  logic             br_eq_i,
   output logic             br_un_o,
   output logic             redirect_valid_o,
   output logic [WIDTH-1:0] redirect_pc_o,
   input  logic             redirect_ready_i,
   output logic             flush_o,
   output logic             stall_ex_o,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] misp_cnt_o
);

   localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);
   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [FC_W-1:0]  r_fcnt;
   logic [FC_W-1:0]  w_fcnt_nxt;
   logic [WIDTH-1:0] r_redirect_pc;
   logic             r_redirect_valid;
   logic             r_flush;
   logic             r_stall;
   logic [1:0]       w_dec;
   logic             w_accept;
   logic             w_misp;

   assign br_un_o  = ex_funct3_i[1];
   assign w_dec    = br_taken(ex_funct3_i, br_lt_i, br_eq_i);
   assign w_accept = (r_state == ST_IDLE) & ex_valid_i & ex_is_br_i & w_dec[1];
   assign w_misp   = w_accept & ~w_dec[0];

   // Next-state and flush-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      case (r_state)
         ST_IDLE: begin
            if (w_misp) begin
               w_state_nxt = ST_REDIRECT;
               w_fcnt_nxt  = FC_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready_i) begin
               if (r_fcnt != '0) begin
                  w_state_nxt = ST_FLUSH;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_state_nxt = ST_REDIRECT;
            end
         end
         ST_FLUSH: begin
            // Counter holds the FLUSH cycles still to go, including this one.
            if (r_fcnt > FC_ONE) begin
               w_fcnt_nxt  = r_fcnt - FC_ONE;
               w_state_nxt = ST_FLUSH;
            end else begin
               w_fcnt_nxt  = '0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_fcnt_nxt  = '0;
         end
      endcase
   end

   // State, counter and registered control outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state          <= ST_IDLE;
         r_fcnt           <= '0;
         r_redirect_valid <= 1'b0;
         r_flush          <= 1'b0;
         r_stall          <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_fcnt           <= w_fcnt_nxt;
         r_redirect_valid <= (w_state_nxt == ST_REDIRECT);
         r_flush          <= (w_state_nxt != ST_IDLE);
         r_stall          <= (w_state_nxt != ST_IDLE);
      end
   end

   // Redirect target captured on mispredict and held through the handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_redirect_pc <= '0;
      end else if (w_misp) begin
         r_redirect_pc <= ex_pc_i + PC_STEP;
      end else begin
         r_redirect_pc <= r_redirect_pc;
      end
   end

   assign redirect_valid_o = r_redirect_valid;
   assign redirect_pc_o    = r_redirect_pc;
   assign flush_o          = r_flush;
   assign stall_ex_o       = r_stall;

   sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_inc   (w_accept),
      .i_clr   (cnt_clr_i),
      .o_cnt   (br_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_misp_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_inc   (w_misp),
      .i_clr   (cnt_clr_i),
      .o_cnt   (misp_cnt_o)
   );

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Execute-stage controller that sequences the branch comparator for an always-taken fetch policy.
- Drives the comparator's unsigned-select from funct3 and evaluates its less-than/equal results into an actual-taken decision.
- On mispredict (branch resolved not-taken), issues a redirect to fetch with a valid/ready handshake, then flushes and stalls the front end.
- Keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- WIDTH, 32, PC/address width.
- FLUSH_CYCLES, 2, total cycles flush_o is asserted per mispredict. Minimum 1.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- ex_valid_i  in  1  EX stage holds a valid instruction.
- ex_is_br_i  in  1  EX instruction is a conditional branch.
- ex_funct3_i  in  3  branch funct3.
- ex_pc_i  in  WIDTH  PC of the EX instruction.
- br_lt_i  in  1  comparator less-than result.
- br_eq_i  in  1  comparator equal result.
- br_un_o  out  1  unsigned-compare select to the comparator.
- redirect_valid_o  out  1  redirect request to fetch.
- redirect_pc_o  out  WIDTH  redirect target.
- redirect_ready_i  in  1  fetch accepts the redirect.
- flush_o  out  1  kill IF/ID contents.
- stall_ex_o  out  1  hold the EX stage.
- cnt_clr_i  in  1  synchronous clear of both counters.
- br_cnt_o  out  CNT_W  resolved branches.
- misp_cnt_o  out  CNT_W  mispredicted branches.

Behaviour:
- br_un_o = ex_funct3_i[1], combinational, always driven regardless of state.
- Actual taken, by funct3:
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT: lt
  - 101 BGE: !lt
  - 110 BLTU: lt
  - 111 BGEU: !lt
  - 010/011: not a legal branch. Ignored: no count, no redirect.
- Accept: a legal branch is accepted in IDLE when ex_valid_i & ex_is_br_i. Inputs are ignored in every other state.
- Mispredict = accepted & !taken. Taken branches need no action because fetch has already gone to the target.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE, on mispredict in cycle N:
  - Register redirect_pc_o = ex_pc_i + 4, modulo 2^WIDTH (wraps).
  - Load flush counter with FLUSH_CYCLES-1.
  - Go to REDIRECT at N+1.
- REDIRECT:
  - redirect_valid_o=1, flush_o=1, stall_ex_o=1.
  - redirect_pc_o is held stable until the handshake completes.
  - On redirect_ready_i: go to FLUSH if the counter is non-zero, else IDLE.
  - Otherwise stay, with unbounded wait allowed.
- FLUSH:
  - flush_o=1, stall_ex_o=1, redirect_valid_o=0.
  - Decrement the counter each cycle; go to IDLE when it reaches 0.
- Flush length: flush_o covers exactly FLUSH_CYCLES cycles when ready is high on the first REDIRECT cycle. Each extra stall cycle in REDIRECT extends it by one.
- Latency: mispredict to redirect_valid_o is 1 cycle.
- Counters:
  - br_cnt increments on every accept; misp_cnt increments on every mispredict.
  - Both saturate at all-ones.
  - cnt_clr_i wins over a same-cycle increment.
- Reset, including mid-operation:
  - State returns to IDLE.
  - redirect_valid_o=0, flush_o=0, stall_ex_o=0, redirect_pc_o=0, br_cnt_o=0, misp_cnt_o=0, internal counter=0.
  - Any pending redirect is dropped.

Decomposition:
- Package branch_ctrl_pkg holds:
  - state enum (IDLE, REDIRECT, FLUSH);
  - funct3 localparams F3_BEQ..F3_BGEU;
  - a function br_taken(funct3, lt, eq) returning {legal, taken}.
- One sub-module, sat_counter (parameter CNT_W; inputs inc, clr), instantiated twice.

Test Plan:
- BEQ taken: funct3=000, eq=1, pc=0x100 → no redirect; br_cnt=1, misp_cnt=0; stall/flush stay 0.
- BNE not-taken: funct3=001, eq=1, pc=0x200, ready=1 →
  - next cycle: redirect_valid=1, redirect_pc=0x204, flush=1;
  - following cycle: flush=1, valid=0;
  - then IDLE; misp_cnt=1.
- BLTU select: funct3=110 → br_un_o=1; funct3=100 → br_un_o=0; lt=0 on BLT produces a mispredict.
- Backpressure: mispredict with ready held 0 for 3 cycles →
  - redirect_valid and redirect_pc stable for 4 cycles;
  - EX inputs presented during this time are not counted;
  - flush lasts 5 cycles total.
- Wrap and counters:
  - pc=0xFFFF_FFFC not-taken → redirect_pc=0x0000_0000.
  - With CNT_W=2, 5 branches → br_cnt=3.
  - cnt_clr with a simultaneous branch → 0.
- Reset mid-REDIRECT: rst_ni low asynchronously → all outputs 0 immediately; after release the block is in IDLE and accepts a new branch.
